mshf_req_sched: RTL

MSHF_REQ_SCHED -- requirements
Module: mshf_req_sched

---
 rtl/vlsu_pkg.sv | 28 ++
 rtl/mshf_req_sched_if.sv | 42 ++++
 rtl/CircularQueuePtrTemplate.sv | 39 +++
 rtl/mshf_req_sched.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vlsu_pkg.sv
// vlsu_pkg: shared types and defaults for the load-side request scheduler.
//   - DefMaxOutst / DefBurstLimit: default in-flight and burst limits.
//   - req_id_t / cmt_cnt_t: descriptor field types.
//   - meta_glb_def_t: default request descriptor (reqId, cmtCnt).
//   - sched_state_e: scheduler FSM state encoding.
package vlsu_pkg;

  localparam int unsigned DefMaxOutst   = 4;
  localparam int unsigned DefBurstLimit = 8;
  localparam int unsigned ReqIdW        = 4;
  localparam int unsigned CmtCntW       = 4;

  typedef logic [ReqIdW-1:0]  req_id_t;
  typedef logic [CmtCntW-1:0] cmt_cnt_t;

  // cmtCnt is the number of commits minus one that the request needs.
  typedef struct packed {
    req_id_t  reqId;
    cmt_cnt_t cmtCnt;
  } meta_glb_def_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

endpackage

// File: rtl/mshf_req_sched_if.sv
// mshf_req_sched_if: bundle of the scheduler's requester, deshuffle, commit
// and status signals.
//   master modport: the environment (requesters + deshuffle unit).
//   slave modport : the scheduler.
// Handshake rule for req and meta channels: a transfer happens on a clock
// edge where valid && ready; valid never waits for ready, and a valid
// descriptor is held stable until accepted.
interface mshf_req_sched_if
  import vlsu_pkg::*;
#(
  parameter int unsigned NrReq = 2,
  parameter int unsigned IdxW  = 1
) ();

  logic [NrReq-1:0]                req_valid;
  logic [NrReq-1:0]                req_ready;
  meta_glb_def_t [NrReq-1:0]       req;
  logic                            meta_valid;
  logic                            meta_ready;
  meta_glb_def_t                   meta;
  logic                            cmt_fire;
  logic                            owner_valid;
  logic [IdxW-1:0]                 owner_id;
  logic                            done_valid;
  req_id_t                         done_req_id;
  logic                            err;
  sched_state_e                    dbg_state;
  logic [$clog2(DefMaxOutst+1)-1:0] dbg_outst;

  modport master (
    output req_valid, req, meta_ready, cmt_fire,
    input  req_ready, meta_valid, meta, owner_valid, owner_id,
           done_valid, done_req_id, err, dbg_state, dbg_outst
  );

  modport slave (
    input  req_valid, req, meta_ready, cmt_fire,
    output req_ready, meta_valid, meta, owner_valid, owner_id,
           done_valid, done_req_id, err, dbg_state, dbg_outst
  );

endinterface

// File: rtl/CircularQueuePtrTemplate.sv
// CircularQueuePtrTemplate: circular queue pointer as a value+flag pair.
// The flag toggles on every wrap so two pointers with equal values can be
// told apart (equal flags = empty, different flags = full).
//   clk_i, rst_ni : clock, async active-low reset
//   incr_i        : advance pointer by one
//   value_o       : slot index
//   flag_o        : wrap flag
module CircularQueuePtrTemplate #(
  parameter int unsigned Depth = 4,
  parameter int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            incr_i,
  output logic [PtrW-1:0] value_o,
  output logic            flag_o
);

  logic [PtrW-1:0] value_q;
  logic            flag_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
      flag_q  <= 1'b0;
    end else if (incr_i) begin
      if (32'(value_q) == Depth - 1) begin
        value_q <= '0;
        flag_q  <= ~flag_q;
      end else begin
        value_q <= value_q + PtrW'(1);
      end
    end
  end

  assign value_o = value_q;
  assign flag_o  = flag_q;

endmodule

// File: rtl/mshf_req_sched.sv
// mshf_req_sched: grants the shared deshuffle datapath to one load requester
// at a time, forwards its descriptors, and tracks per-request commit counts.
//   clk_i, rst_ni          : clock, async active-low reset
//   req_valid_i/ready_o/i  : per-requester descriptor channels
//   meta_valid_o/ready_i/o : forwarded descriptor to the deshuffle unit
//   cmt_fire_i             : one deshuffle commit
//   owner_valid_o/id_o     : current datapath owner (lane-mux steering)
//   done_valid_o/req_id_o  : one-cycle pulse when a request fully commits
//   err_o                  : sticky, commit seen with nothing in flight
//   dbg_state_o/outst_o    : FSM state and in-flight count
// Handshake rule: transfer on a clock edge with valid && ready; meta_valid_o
// is computed without looking at meta_ready_i.
module mshf_req_sched
  import vlsu_pkg::*;
#(
  parameter int unsigned NrReq      = 2,
  parameter int unsigned MaxOutst   = DefMaxOutst,
  parameter int unsigned BurstLimit = DefBurstLimit,
  parameter type         meta_glb_t = meta_glb_def_t,
  parameter int unsigned IdxW       = (NrReq > 1) ? $clog2(NrReq) : 1,
  parameter int unsigned OutstW     = $clog2(MaxOutst + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NrReq-1:0]       req_valid_i,
  output logic [NrReq-1:0]       req_ready_o,
  input  meta_glb_t [NrReq-1:0]  req_i,
  output logic                   meta_valid_o,
  input  logic                   meta_ready_i,
  output meta_glb_t              meta_o,
  input  logic                   cmt_fire_i,
  output logic                   owner_valid_o,
  output logic [IdxW-1:0]        owner_id_o,
  output logic                   done_valid_o,
  output req_id_t                done_req_id_o,
  output logic                   err_o,
  output sched_state_e           dbg_state_o,
  output logic [OutstW-1:0]      dbg_outst_o
);

  localparam int unsigned PtrW   = (MaxOutst > 1) ? $clog2(MaxOutst) : 1;
  localparam int unsigned BurstW = $clog2(BurstLimit + 1);
  localparam logic [OutstW-1:0] MaxOutstV   = OutstW'(MaxOutst);
  localparam logic [BurstW-1:0] BurstLimitV = BurstW'(BurstLimit);

  sched_state_e      state_q;
  logic [IdxW-1:0]   owner_q, rr_ptr_q;
  logic [OutstW-1:0] outst_q, outst_d;
  logic [BurstW-1:0] burst_q;
  logic              owner_valid_q, err_q;

  cmt_cnt_t rem_q [MaxOutst];
  req_id_t  id_q  [MaxOutst];

  logic [PtrW-1:0] enq_val, deq_val;
  logic            enq_flag, deq_flag;

  // First valid requester at or after start, wrapping around.
  function automatic logic [IdxW-1:0] rr_pick(input logic [NrReq-1:0] vld,
                                              input logic [IdxW-1:0]  start);
    logic [IdxW-1:0] sel;
    logic            found;
    int unsigned     idx;
    sel   = start;
    found = 1'b0;
    for (int unsigned k = 0; k < NrReq; k++) begin
      idx = (32'(start) + k) % NrReq;
      if (!found && vld[IdxW'(idx)]) begin
        sel   = IdxW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [IdxW-1:0] inc_idx(input logic [IdxW-1:0] x);
    return (32'(x) == NrReq - 1) ? '0 : x + IdxW'(1);
  endfunction

  logic [NrReq-1:0] owner_oh, others_vld;
  logic             others_any, owner_req_valid, has_room, burst_full;
  logic             drain_go, accept_ok, push, pop, cmt_ok, head_zero;
  logic             fifo_empty;
  logic [IdxW-1:0]  next_owner;

  assign owner_oh        = NrReq'(1) << owner_q;
  assign others_vld      = req_valid_i & ~owner_oh;
  assign others_any      = |others_vld;
  assign owner_req_valid = req_valid_i[owner_q];
  assign has_room        = outst_q < MaxOutstV;
  assign burst_full      = burst_q == BurstLimitV;
  assign next_owner      = rr_pick(others_vld, inc_idx(owner_q));

  // Once the yield condition holds, stop accepting so the burst ends at
  // exactly BurstLimit and nothing new is queued behind the drain.
  assign drain_go  = (state_q == ST_OWN) && others_any &&
                     (!owner_req_valid || burst_full);
  assign accept_ok = (state_q == ST_OWN) && has_room && !drain_go;

  assign meta_valid_o = accept_ok && owner_req_valid;
  assign meta_o       = req_i[owner_q];
  assign req_ready_o  = (accept_ok && meta_ready_i) ? owner_oh : '0;
  assign push         = meta_valid_o && meta_ready_i;

  assign fifo_empty = (enq_val == deq_val) && (enq_flag == deq_flag);
  assign cmt_ok     = cmt_fire_i && !fifo_empty;
  assign head_zero  = rem_q[deq_val] == '0;
  assign pop        = cmt_ok && head_zero;

  assign done_valid_o  = pop;
  assign done_req_id_o = id_q[deq_val];

  always_comb begin
    outst_d = outst_q;
    if (push && !pop)      outst_d = outst_q + OutstW'(1);
    else if (pop && !push) outst_d = outst_q - OutstW'(1);
  end

  CircularQueuePtrTemplate #(.Depth(MaxOutst)) u_enq_ptr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .incr_i  (push),
    .value_o (enq_val),
    .flag_o  (enq_flag)
  );

  CircularQueuePtrTemplate #(.Depth(MaxOutst)) u_deq_ptr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .incr_i  (pop),
    .value_o (deq_val),
    .flag_o  (deq_flag)
  );

  // Push only happens when not full, so a same-cycle push and head
  // decrement always touch different slots.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MaxOutst); i++) begin
        rem_q[i] <= '0;
        id_q[i]  <= '0;
      end
    end else begin
      if (cmt_ok && !head_zero) rem_q[deq_val] <= rem_q[deq_val] - cmt_cnt_t'(1);
      if (push) begin
        rem_q[enq_val] <= meta_o.cmtCnt;
        id_q[enq_val]  <= meta_o.reqId;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      burst_q       <= '0;
      outst_q       <= '0;
      owner_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      outst_q <= outst_d;
      if (cmt_fire_i && outst_q == '0) err_q <= 1'b1;
      if (push && !burst_full) burst_q <= burst_q + BurstW'(1);
      case (state_q)
        ST_IDLE: begin
          if (|req_valid_i) begin
            owner_q       <= rr_pick(req_valid_i, rr_ptr_q);
            burst_q       <= '0;
            owner_valid_q <= 1'b1;
            state_q       <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (drain_go) begin
            state_q <= ST_DRAIN;
          end else if (outst_q == '0 && !(|req_valid_i)) begin
            state_q       <= ST_IDLE;
            owner_valid_q <= 1'b0;
            rr_ptr_q      <= inc_idx(owner_q);
          end
        end
        ST_DRAIN: begin
          if (outst_q == '0) begin
            if (others_any) begin
              owner_q  <= next_owner;
              rr_ptr_q <= inc_idx(next_owner);
              burst_q  <= '0;
              state_q  <= ST_OWN;
            end else begin
              // Waiting requester went away: release and re-arbitrate.
              state_q       <= ST_IDLE;
              owner_valid_q <= 1'b0;
              rr_ptr_q      <= inc_idx(owner_q);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign owner_valid_o = owner_valid_q;
  assign owner_id_o    = owner_q;
  assign err_o         = err_q;
  assign dbg_state_o   = state_q;
  assign dbg_outst_o   = outst_q;

endmodule
